codpri_arb: RTL and testbench

- Parametrised, registered successor to the 4-input priority encoder with enable.
- Accepts N request lines and grants one of them, using either fixed priority (highest index wins) or round-robin.
- Holds the grant until the requester signals done, then releases it.
- Sits in front of a shared resource (bus or output port) that several requesters use in turn.

---
 rtl/codpri_pkg.sv | 14 +
 rtl/codpri_n.sv | 23 ++
 rtl/codpri_arb.sv | 133 +++++++++++++
 tb/tb_codpri_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/codpri_pkg.sv
// Shared constants and types for the codpri arbiter family.
package codpri_pkg;

  // Arbitration policy selectors for the MODE parameter.
  localparam int MODO_FIXO = 0;  // fixed priority, highest index wins
  localparam int MODO_RR   = 1;  // round-robin, last grantee becomes lowest

  // Arbiter FSM state encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } st_t;

endpackage

// File: rtl/codpri_n.sv
// Combinational N-input priority encoder: highest set index wins.
module codpri_n #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan, so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (vec[k]) begin
        idx = W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/codpri_arb.sv
// Registered N-way arbiter: fixed priority or round-robin, grant held until done.
//
// Handshake: req[k] is a level request. Once valid=1, gnt/y stay frozen until
// the grantee pulses done (release) or en drops (abort); either returns the
// arbiter to IDLE for at least one cycle before the next grant is issued.
module codpri_arb
  import codpri_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODO_FIXO,
  localparam int W    = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic         valid,
  output logic [W-1:0] y,
  output logic [N-1:0] gnt,
  output st_t          dbg_state
);

  st_t          state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] y_d;
  logic [N-1:0] gnt_d;
  logic         valid_d;

  logic [N-1:0] rot;
  logic [N-1:0] enc_in;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic [W-1:0] winner;

  // Rotate req so that index ptr-1 lands on the encoder's top bit (highest
  // priority) and index ptr lands on bit 0 (lowest priority).
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[W'((j + int'(ptr_q)) % N)];
    end
  end

  // Fixed mode encodes req directly; round-robin encodes the rotated view.
  always_comb begin
    enc_in = (MODE == MODO_RR) ? rot : req;
  end

  codpri_n #(.N(N)) u_enc (
    .vec (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Undo the rotation to recover the real requester index (mod N).
  always_comb begin
    if (MODE == MODO_RR) begin
      winner = W'((int'(enc_idx) + int'(ptr_q)) % N);
    end else begin
      winner = enc_idx;
    end
  end

  // Next-state and next-output logic; outputs are held by default in GRANT.
  always_comb begin
    state_d = state_q;
    valid_d = valid;
    y_d     = y;
    gnt_d   = gnt;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        y_d     = '0;
        gnt_d   = '0;
        if (en && enc_any) begin
          state_d        = ST_GRANT;
          valid_d        = 1'b1;
          y_d            = winner;
          gnt_d[winner]  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (done) begin
          // Release: the grantee becomes lowest priority in round-robin.
          state_d = ST_IDLE;
          valid_d = 1'b0;
          y_d     = '0;
          gnt_d   = '0;
          if (MODE == MODO_RR) begin
            ptr_d = y;
          end
        end else if (!en) begin
          // Abort: drop the grant without touching the rotation pointer.
          state_d = ST_IDLE;
          valid_d = 1'b0;
          y_d     = '0;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        y_d     = '0;
        gnt_d   = '0;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid   <= 1'b0;
      y       <= '0;
      gnt     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      valid   <= valid_d;
      y       <= y_d;
      gnt     <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM state made visible for external checkers.
  always_comb begin
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_codpri_arb.sv
// Directed bench for codpri_arb: one fixed-priority and one round-robin
// instance driven by the same inputs, checked against hand-computed rows.
module tb_codpri_arb;
  import codpri_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         en;
  logic [N-1:0] req;
  logic         done;

  logic         f_valid, r_valid;
  logic [W-1:0] f_y, r_y;
  logic [N-1:0] f_gnt, r_gnt;
  st_t          f_st, r_st;

  codpri_arb #(.N(N), .MODE(MODO_FIXO)) u_fix (
    .clock (clk), .reset (rst), .en (en), .req (req), .done (done),
    .valid (f_valid), .y (f_y), .gnt (f_gnt), .dbg_state (f_st)
  );

  codpri_arb #(.N(N), .MODE(MODO_RR)) u_rr (
    .clock (clk), .reset (rst), .en (en), .req (req), .done (done),
    .valid (r_valid), .y (r_y), .gnt (r_gnt), .dbg_state (r_st)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // Expected {valid, y, gnt} word for a given grant outcome.
  function automatic logic [11:0] pack(input logic v, input logic [W-1:0] yy);
    logic [N-1:0] g;
    g = 8'b0000_0001 << yy;
    return v ? {1'b1, yy, g} : 12'h000;
  endfunction

  task automatic check(input string name, input int row, input logic [11:0] act);
    logic [11:0] e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s row %0d: got v/y/gnt=%h required %h", name, row, act, e);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic         done;
    logic         fv;
    logic [W-1:0] fy;
    logic         rv;
    logic [W-1:0] ry;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [N-1:0] q, input logic d,
                     input logic fv, input logic [W-1:0] fy,
                     input logic rv, input logic [W-1:0] ry);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.done = d;
    v.fv = fv; v.fy = fy; v.rv = rv; v.ry = ry;
    tbl.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic [N-1:0] q, input logic d);
    rst = r; en = e; req = q; done = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0);

    // Idle behaviour: no requests, then requests with en low.
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 0, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 0, 8'hFF, 0, 0, 0, 0, 0);
    // Grant freeze on req change, release, re-grant.
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h26, 0, 1, 5, 1, 5);
    add(0, 1, 8'h80, 0, 1, 5, 1, 5);
    add(0, 1, 8'h80, 1, 0, 0, 0, 0);
    add(0, 1, 8'h80, 0, 1, 7, 1, 7);
    // All requesting: fixed stays on 7, round-robin walks 7..0..7.
    add(1, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 1, 7, 1, 7);
    for (int k = 6; k >= 0; k--) begin
      add(0, 1, 8'hFF, 1, 0, 0, 0, 0);
      add(0, 1, 8'hFF, 0, 1, 7, 1, W'(k));
    end
    add(0, 1, 8'hFF, 1, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 1, 7, 1, 7);
    // Two requesters at the ends: RR alternates 7,0; fixed sticks on 7.
    add(1, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h81, 0, 1, 7, 1, 7);
    add(0, 1, 8'h81, 1, 0, 0, 0, 0);
    add(0, 1, 8'h81, 0, 1, 7, 1, 0);
    add(0, 1, 8'h81, 1, 0, 0, 0, 0);
    add(0, 1, 8'h81, 0, 1, 7, 1, 7);
    add(0, 1, 8'h81, 1, 0, 0, 0, 0);
    add(0, 1, 8'h81, 0, 1, 7, 1, 0);
    // Abort on en drop leaves ptr untouched.
    add(1, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h40, 0, 1, 6, 1, 6);
    add(0, 0, 8'h40, 0, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 1, 7, 1, 7);
    // Reset mid-grant clears ptr back to 0.
    add(1, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 1, 7, 1, 7);
    add(0, 1, 8'hFF, 1, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 1, 7, 1, 6);
    add(1, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 1, 7, 1, 7);
    // done in IDLE must not disturb anything.
    add(1, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 0, 0);
    add(0, 1, 8'h0C, 0, 1, 3, 1, 3);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].done);
      step();
      exp_q.push_back(pack(tbl[i].fv, tbl[i].fy));
      check("fix", i, {f_valid, f_y, f_gnt});
      exp_q.push_back(pack(tbl[i].rv, tbl[i].ry));
      check("rr", i, {r_valid, r_y, r_gnt});
    end

    // Single requester with done held high: grant / idle / grant ...
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h08, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      exp_q.push_back(pack((c % 2) == 0, 3'd3));
      check("rr_single", c, {r_valid, r_y, r_gnt});
      checks++;
      if (r_st !== (((c % 2) == 0) ? ST_GRANT : ST_IDLE)) begin
        errors++;
        $display("FAIL rr_single_state cycle %0d: got %0d required %0d",
                 c, r_st, ((c % 2) == 0) ? 1 : 0);
      end
    end

    // Bounded wait for a grant after a fresh request.
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h04, 1'b0);
    begin
      int budget;
      budget = 0;
      while (!r_valid && budget < 5) begin
        step();
        budget++;
      end
      checks++;
      if (!r_valid) begin
        errors++;
        $display("FAIL rr_wait: got no grant within 5 cycles required valid=1");
      end else if (budget != 1) begin
        errors++;
        $display("FAIL rr_latency: got %0d cycles required 1", budget);
      end
      exp_q.push_back(pack(1'b1, 3'd2));
      check("rr_wait_grant", 0, {r_valid, r_y, r_gnt});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
